pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer; next generation of the plain PC register.

---
 rtl/pc_pkg.sv | 7 +
 rtl/pc_ras.sv | 38 +++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, next-PC select codes and default vectors for pc_sequencer.
package pc_pkg;
    typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_e;
    typedef enum logic [2:0] {SEL_HOLD, SEL_SEQ, SEL_TRAP, SEL_ERET, SEL_TARGET, SEL_RET} pc_sel_e;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h80;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW:0]      cnt_q;
    assign top_o   = mem_q[ptr_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && pop_i && !empty_o) begin
            mem_q[ptr_q] <= data_i;
        end else if (push_i) begin
            ptr_q                <= ptr_q + 1'b1;
            mem_q[ptr_q + 1'b1]  <= data_i;
            if (!full_o) cnt_q   <= cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with trap/eret/redirect/return selection, stall and halt control.
// Define PC_RAS_EN to let Ret take its destination from an internal return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(PC_TRAP_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             FetchReady,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             Resume,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] Target,
    input  logic             Call,
    input  logic             Ret,
    input  logic [WIDTH-1:0] RetTarget,
    input  logic             Trap,
    input  logic             Eret,
    output logic [WIDTH-1:0] Address,
    output logic             FetchValid,
    output logic [WIDTH-1:0] EPC
);
    pc_state_e        state_q, state_d;
    pc_sel_e          sel;
    logic [WIDTH-1:0] addr_q, addr_d, epc_q, epc_d, ret_pc;
    // A Halt in RUN freezes the PC for that cycle unless a Trap overrides it.
    always_comb begin
        sel     = SEL_HOLD;
        state_d = state_q;
        if (Trap) begin
            sel     = SEL_TRAP;
            state_d = PC_RUN;
        end else if (state_q == PC_BOOT) begin
            state_d = PC_RUN;
        end else if (state_q == PC_HALT) begin
            state_d = Resume ? PC_RUN : PC_HALT;
        end else if (Halt) begin
            state_d = PC_HALT;
        end else begin
            sel = Eret ? SEL_ERET : Redirect ? SEL_TARGET : Ret ? SEL_RET :
                  (Stall || !FetchReady) ? SEL_HOLD : SEL_SEQ;
        end
        addr_d = sel == SEL_TRAP   ? TRAP_VECTOR :
                 sel == SEL_ERET   ? epc_q :
                 sel == SEL_TARGET ? Target :
                 sel == SEL_RET    ? ret_pc :
                 sel == SEL_SEQ    ? addr_q + WIDTH'(INC) : addr_q;
        epc_d  = sel == SEL_TRAP ? addr_q : epc_q;
    end
`ifdef PC_RAS_EN
    logic             ras_push, ras_pop, ras_empty, ras_full_unused;
    logic [WIDTH-1:0] ras_top;
    assign ras_push = sel == SEL_TARGET && Call;
    assign ras_pop  = sel == SEL_RET || (ras_push && Ret);
    assign ret_pc   = ras_empty ? RetTarget : ras_top;
    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .Clk    (Clk),
        .Reset  (Reset),
        .push_i (ras_push),
        .pop_i  (ras_pop),
        .data_i (addr_q + WIDTH'(INC)),
        .top_o  (ras_top),
        .empty_o(ras_empty),
        .full_o (ras_full_unused)
    );
`else
    logic unused_call;
    assign unused_call = Call & (RAS_DEPTH > 0);
    assign ret_pc      = RetTarget;
`endif
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= PC_BOOT;
            addr_q  <= RESET_VECTOR;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            epc_q   <= epc_d;
        end
    end
    assign Address    = addr_q;
    assign FetchValid = state_q == PC_RUN;
    assign EPC        = epc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table plus hand sequences for reset, RAS and 8-bit wrap.
module tb_pc_sequencer;
    logic        Clk = 1'b0, Reset = 1'b1;
    logic        FetchReady, Stall, Halt, Resume, Redirect, Call, Ret, Trap, Eret;
    logic [31:0] Target, RetTarget, Address, EPC;
    logic        FetchValid;
    logic        r8_redirect;
    logic [7:0]  r8_target, a8, epc8;
    logic        fv8;
    int          checks = 0, fails = 0;

    localparam logic [8:0] FR = 9'h100, ST = 9'h080, HA = 9'h040, RS = 9'h020, RD = 9'h010,
                           CL = 9'h008, RT = 9'h004, TP = 9'h002, ER = 9'h001;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] target, ret_target, addr, epc;
        logic        fv;
    } vec_t;
    typedef struct {
        logic [31:0] addr, epc;
        logic        fv;
        string       name;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[20];

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .FetchReady(FetchReady), .Stall(Stall), .Halt(Halt),
        .Resume(Resume), .Redirect(Redirect), .Target(Target), .Call(Call), .Ret(Ret),
        .RetTarget(RetTarget), .Trap(Trap), .Eret(Eret), .Address(Address),
        .FetchValid(FetchValid), .EPC(EPC)
    );

    pc_sequencer #(.WIDTH(8)) u8 (
        .Clk(Clk), .Reset(Reset), .FetchReady(1'b1), .Stall(1'b0), .Halt(1'b0),
        .Resume(1'b0), .Redirect(r8_redirect), .Target(r8_target), .Call(1'b0), .Ret(1'b0),
        .RetTarget(8'h0), .Trap(1'b0), .Eret(1'b0), .Address(a8),
        .FetchValid(fv8), .EPC(epc8)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(logic [8:0] ctl, logic [31:0] tg, logic [31:0] rt,
                                logic [31:0] addr, logic fv, logic [31:0] epc);
        vec_t r;
        r.ctl = ctl; r.target = tg; r.ret_target = rt; r.addr = addr; r.fv = fv; r.epc = epc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        {FetchReady, Stall, Halt, Resume, Redirect, Call, Ret, Trap, Eret} = v.ctl;
        Target    = v.target;
        RetTarget = v.ret_target;
        sb.push_back('{addr: v.addr, epc: v.epc, fv: v.fv, name: name});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".addr"}, Address, e.addr);
        check({e.name, ".fv"}, {31'b0, FetchValid}, {31'b0, e.fv});
        check({e.name, ".epc"}, EPC, e.epc);
    endtask

    initial begin
        logic [31:0] exp_ret;
        tbl[0]  = mk(FR,           0,     0,    32'h0,   1, 32'h0);
        tbl[1]  = mk(FR,           0,     0,    32'h4,   1, 32'h0);
        tbl[2]  = mk(FR,           0,     0,    32'h8,   1, 32'h0);
        tbl[3]  = mk(FR,           0,     0,    32'hC,   1, 32'h0);
        tbl[4]  = mk(FR | ST,      0,     0,    32'hC,   1, 32'h0);
        tbl[5]  = mk(FR | ST,      0,     0,    32'hC,   1, 32'h0);
        tbl[6]  = mk(FR | ST | RD, 'h100, 0,    32'h100, 1, 32'h0);
        tbl[7]  = mk(FR,           0,     0,    32'h104, 1, 32'h0);
        tbl[8]  = mk(FR | TP | RD, 'h300, 0,    32'h80,  1, 32'h104);
        tbl[9]  = mk(FR | ER,      0,     0,    32'h104, 1, 32'h104);
        tbl[10] = mk(9'h0,         0,     0,    32'h104, 1, 32'h104);
        tbl[11] = mk(RT,           0,     'h50, 32'h50,  1, 32'h104);
        tbl[12] = mk(FR | HA | RD, 'h200, 0,    32'h50,  0, 32'h104);
        tbl[13] = mk(FR | RD,      'h200, 0,    32'h50,  0, 32'h104);
        tbl[14] = mk(FR | HA | RS, 0,     0,    32'h50,  1, 32'h104);
        tbl[15] = mk(FR,           0,     0,    32'h54,  1, 32'h104);
        tbl[16] = mk(FR | HA,      0,     0,    32'h54,  0, 32'h104);
        tbl[17] = mk(FR | TP,      0,     0,    32'h80,  1, 32'h54);
        tbl[18] = mk(FR | ER | RD, 'h400, 0,    32'h54,  1, 32'h54);
        tbl[19] = mk(FR | RD | RT, 'h400, 'h500, 32'h400, 1, 32'h54);

        {FetchReady, Stall, Halt, Resume, Redirect, Call, Ret, Trap, Eret} = '0;
        Target = '0; RetTarget = '0; r8_redirect = 1'b0; r8_target = '0;
        #6;
        check("reset.addr", Address, 32'h0);
        check("reset.fv", {31'b0, FetchValid}, 32'h0);
        check("reset.epc", EPC, 32'h0);
        Reset = 1'b0;

        for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

        apply(mk(FR | RD, 'h3C, 0, 32'h3C, 1, 32'h54), "pre_rst0");
        apply(mk(FR, 0, 0, 32'h40, 1, 32'h54), "pre_rst1");
        Reset = 1'b1;
        #1;
        check("async_rst.addr", Address, 32'h0);
        check("async_rst.fv", {31'b0, FetchValid}, 32'h0);
        check("async_rst.epc", EPC, 32'h0);
        #1 Reset = 1'b0;
        apply(mk(FR, 0, 0, 32'h0, 1, 32'h0), "boot");
        apply(mk(FR, 0, 0, 32'h4, 1, 32'h0), "boot_seq");

        for (int i = 1; i <= 5; i++) begin
            apply(mk(FR | RD, 32'(i * 16), 0, 32'(i * 16), 1, 32'h0), $sformatf("goto%0d", i));
            apply(mk(FR | RD | CL, 'h100, 0, 32'h100, 1, 32'h0), $sformatf("call%0d", i));
        end
        for (int k = 0; k < 5; k++) begin
`ifdef PC_RAS_EN
            exp_ret = k < 4 ? 32'h54 - 32'(k * 16) : 32'h200;
`else
            exp_ret = 32'h200;
`endif
            apply(mk(FR | RT, 0, 'h200, exp_ret, 1, 32'h0), $sformatf("ret%0d", k));
        end

        r8_redirect = 1'b1;
        r8_target   = 8'hFC;
        @(posedge Clk);
        #1;
        check("w8.fc", {24'b0, a8}, 32'hFC);
        r8_redirect = 1'b0;
        @(posedge Clk);
        #1;
        check("w8.wrap", {24'b0, a8}, 32'h0);
        check("w8.fv", {31'b0, fv8}, 32'h1);
        @(posedge Clk);
        #1;
        check("w8.next", {24'b0, a8}, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
